// File: rtl/pong_score_ctrl.sv
// Pong game-state and scoring controller: scores, round flash, game-over, paddle-hit highlights.
module pong_score_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned FLASH_FRAMES = 30,
  parameter int unsigned HIT_FRAMES   = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       goalL,
  input  logic       goalR,
  input  logic       hitP1,
  input  logic       hitP2,
  input  logic       start,
  output logic [3:0] scoreL,
  output logic [3:0] scoreR,
  output logic       paddle1Hit,
  output logic       paddle2Hit,
  output logic       nGame,
  output logic       eGame,
  output logic       ball_reset
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned FLASH_W = 6;
  localparam int unsigned HIT_W   = 4;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               frame_d;
  logic               tick;
  logic [FLASH_W-1:0] flash_cnt;
  logic [FLASH_W-1:0] flash_cnt_nx;
  logic [HIT_W-1:0]   hit1_cnt;
  logic [HIT_W-1:0]   hit1_cnt_nx;
  logic [HIT_W-1:0]   hit2_cnt;
  logic [HIT_W-1:0]   hit2_cnt_nx;
  logic [SCORE_W-1:0] score_l_nx;
  logic [SCORE_W-1:0] score_r_nx;
  logic               ball_reset_nx;
  logic               hits_clear;

  // Rising edge of the frame-rate level signal; frame_d resets high so a
  // frame_clk already high at reset release is not counted.
  assign tick = frame_clk & ~frame_d;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= PLAY;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, score update, flash countdown and serve request.
  always_comb begin
    state_nx      = state;
    flash_cnt_nx  = flash_cnt;
    score_l_nx    = scoreL;
    score_r_nx    = scoreR;
    ball_reset_nx = 1'b0;
    unique case (state)
      PLAY: begin
        // Left goal has priority; a simultaneous right goal is dropped.
        if (goalL) begin
          if (scoreL < SCORE_W'(WIN_SCORE)) begin
            score_l_nx = scoreL + SCORE_W'(1);
          end
          if (score_l_nx == SCORE_W'(WIN_SCORE)) begin
            state_nx = OVER;
          end else begin
            state_nx     = FLASH;
            flash_cnt_nx = FLASH_W'(FLASH_FRAMES);
          end
        end else if (goalR) begin
          if (scoreR < SCORE_W'(WIN_SCORE)) begin
            score_r_nx = scoreR + SCORE_W'(1);
          end
          if (score_r_nx == SCORE_W'(WIN_SCORE)) begin
            state_nx = OVER;
          end else begin
            state_nx     = FLASH;
            flash_cnt_nx = FLASH_W'(FLASH_FRAMES);
          end
        end
      end
      FLASH: begin
        if (tick) begin
          if (flash_cnt <= FLASH_W'(1)) begin
            flash_cnt_nx  = '0;
            state_nx      = PLAY;
            ball_reset_nx = 1'b1;
          end else begin
            flash_cnt_nx = flash_cnt - FLASH_W'(1);
          end
        end
      end
      OVER: begin
        if (start) begin
          score_l_nx    = '0;
          score_r_nx    = '0;
          state_nx      = PLAY;
          ball_reset_nx = 1'b1;
        end
      end
      default: begin
        state_nx = PLAY;
      end
    endcase
  end

  // Paddle highlight counters: load on hit, count down on ticks, cleared in game-over.
  always_comb begin
    hits_clear  = (state == OVER) || (state_nx == OVER);
    hit1_cnt_nx = hit1_cnt;
    hit2_cnt_nx = hit2_cnt;
    if (hits_clear) begin
      hit1_cnt_nx = '0;
    end else if (hitP1) begin
      hit1_cnt_nx = HIT_W'(HIT_FRAMES);
    end else if (tick && (hit1_cnt != '0)) begin
      hit1_cnt_nx = hit1_cnt - HIT_W'(1);
    end
    if (hits_clear) begin
      hit2_cnt_nx = '0;
    end else if (hitP2) begin
      hit2_cnt_nx = HIT_W'(HIT_FRAMES);
    end else if (tick && (hit2_cnt != '0)) begin
      hit2_cnt_nx = hit2_cnt - HIT_W'(1);
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d    <= 1'b1;
      flash_cnt  <= '0;
      hit1_cnt   <= '0;
      hit2_cnt   <= '0;
      scoreL     <= '0;
      scoreR     <= '0;
      paddle1Hit <= 1'b0;
      paddle2Hit <= 1'b0;
      nGame      <= 1'b0;
      eGame      <= 1'b0;
      ball_reset <= 1'b0;
    end else begin
      frame_d    <= frame_clk;
      flash_cnt  <= flash_cnt_nx;
      hit1_cnt   <= hit1_cnt_nx;
      hit2_cnt   <= hit2_cnt_nx;
      scoreL     <= score_l_nx;
      scoreR     <= score_r_nx;
      paddle1Hit <= (hit1_cnt_nx != '0);
      paddle2Hit <= (hit2_cnt_nx != '0);
      nGame      <= (state_nx == FLASH);
      eGame      <= (state_nx == OVER);
      ball_reset <= ball_reset_nx;
    end
  end

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Self-checking bench for pong_score_ctrl: expected output vectors queued per driven cycle.
module tb_pong_score_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       goalL = 1'b0;
  logic       goalR = 1'b0;
  logic       hitP1 = 1'b0;
  logic       hitP2 = 1'b0;
  logic       start = 1'b0;
  logic [3:0] scoreL;
  logic [3:0] scoreR;
  logic       paddle1Hit;
  logic       paddle2Hit;
  logic       nGame;
  logic       eGame;
  logic       ball_reset;

  typedef struct {
    string       name;
    logic [14:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [14:0] obs;
  int          total = 0;
  int          bad = 0;

  // Observed vector: scoreL, scoreR, paddle1Hit, paddle2Hit, nGame, eGame, ball_reset.
  assign obs = {scoreL, scoreR, paddle1Hit, paddle2Hit, nGame, eGame, ball_reset};

  pong_score_ctrl #(
    .WIN_SCORE(9),
    .FLASH_FRAMES(30),
    .HIT_FRAMES(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .goalL(goalL),
    .goalR(goalR),
    .hitP1(hitP1),
    .hitP2(hitP2),
    .start(start),
    .scoreL(scoreL),
    .scoreR(scoreR),
    .paddle1Hit(paddle1Hit),
    .paddle2Hit(paddle2Hit),
    .nGame(nGame),
    .eGame(eGame),
    .ball_reset(ball_reset)
  );

  always #5 Clk = ~Clk;

  function automatic logic [14:0] pk(input logic [3:0] sl, input logic [3:0] sr,
                                     input logic p1, input logic p2, input logic ng,
                                     input logic eg, input logic br);
    return {sl, sr, p1, p2, ng, eg, br};
  endfunction

  task automatic push(input string nm, input logic [14:0] v);
    exp_t x;
    x.name = nm;
    x.v    = v;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  // Thirty frame ticks, two clock cycles each, leaving frame_clk low.
  task automatic run_flash();
    for (int c = 0; c < 60; c++) begin
      frame_clk = (c % 2 == 0);
      step();
    end
    frame_clk = 1'b0;
  endtask

  task automatic score_goal(input logic left);
    goalL = left;
    goalR = ~left;
    step();
    goalL = 1'b0;
    goalR = 1'b0;
    run_flash();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    goalL = 1'b1;
    push("reset_state", pk(0, 0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    goalL = 1'b0;
    Reset = 1'b0;
    push("after_release", pk(0, 0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
  endtask

  task automatic test_goal_flash();
    do_reset();
    goalL = 1'b1;
    push("goal_l", pk(1, 0, 0, 0, 1, 0, 0));
    step();
    goalL = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    for (int c = 0; c < 60; c++) begin
      frame_clk = (c % 2 == 0);
      push($sformatf("flash_cyc%0d", c), pk(1, 0, 0, 0, c < 58, 0, c == 58));
      step();
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    end
    frame_clk = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    goalL = 1'b1;
    goalR = 1'b1;
    push("both_goals", pk(1, 0, 0, 0, 1, 0, 0));
    step();
    goalL = 1'b0;
    goalR = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    goalR = 1'b1;
    push("goal_in_flash", pk(1, 0, 0, 0, 1, 0, 0));
    step();
    goalR = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    run_flash();
    push("back_to_play", pk(1, 0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    goalR = 1'b1;
    push("goal_r_after", pk(1, 1, 0, 0, 1, 0, 0));
    step();
    goalR = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
  endtask

  task automatic test_game_over();
    do_reset();
    for (int g = 0; g < 8; g++) score_goal(1'b0);
    push("score_r_8", pk(0, 8, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    goalR = 1'b1;
    hitP1 = 1'b1;
    push("win_r", pk(0, 9, 0, 0, 0, 1, 0));
    step();
    goalR = 1'b0;
    hitP1 = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    for (int c = 0; c < 6; c++) begin
      goalL     = (c == 0);
      goalR     = (c == 1);
      hitP1     = (c == 2);
      hitP2     = (c == 3);
      frame_clk = (c % 2 == 0);
      push($sformatf("over_hold%0d", c), pk(0, 9, 0, 0, 0, 1, 0));
      step();
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    end
    goalL = 1'b0; goalR = 1'b0; hitP1 = 1'b0; hitP2 = 1'b0; frame_clk = 1'b0;
    start = 1'b1;
    push("restart", pk(0, 0, 0, 0, 0, 0, 1));
    step();
    start = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    push("restart_br_single", pk(0, 0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
  endtask

  task automatic test_hit_restart();
    do_reset();
    frame_clk = 1'b0;
    hitP1 = 1'b1;
    push("hit1_load", pk(0, 0, 1, 0, 0, 0, 0));
    step();
    hitP1 = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    for (int c = 0; c < 10; c++) begin
      frame_clk = (c % 2 == 0);
      push($sformatf("hit1_early%0d", c), pk(0, 0, 1, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    end
    // Re-hit lands on a tick: the fresh load must not be decremented.
    hitP1 = 1'b1;
    frame_clk = 1'b1;
    push("hit1_retrigger", pk(0, 0, 1, 0, 0, 0, 0));
    step();
    hitP1 = 1'b0;
    frame_clk = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    push("hit1_post_retrigger", pk(0, 0, 1, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    for (int c = 0; c < 16; c++) begin
      frame_clk = (c % 2 == 0);
      push($sformatf("hit1_decay%0d", c), pk(0, 0, c < 14, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    end
    frame_clk = 1'b0;
  endtask

  task automatic test_reset_frame_high();
    frame_clk = 1'b1;
    do_reset();
    goalL = 1'b1;
    push("goal_at_release", pk(1, 0, 0, 0, 1, 0, 0));
    step();
    goalL = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    push("frame_held_high", pk(1, 0, 0, 0, 1, 0, 0));
    step();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    frame_clk = 1'b0;
    push("frame_low", pk(1, 0, 0, 0, 1, 0, 0));
    step();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    for (int c = 0; c < 60; c++) begin
      frame_clk = (c % 2 == 0);
      push($sformatf("rel_flash%0d", c), pk(1, 0, 0, 0, c < 58, 0, c == 58));
      step();
      e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    end
    frame_clk = 1'b0;
  endtask

  task automatic test_reset_mid_flash();
    do_reset();
    for (int g = 0; g < 3; g++) score_goal(1'b1);
    for (int g = 0; g < 3; g++) score_goal(1'b0);
    goalR = 1'b1;
    hitP2 = 1'b1;
    push("flash_3_4", pk(3, 4, 0, 1, 1, 0, 0));
    step();
    goalR = 1'b0;
    hitP2 = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    for (int c = 0; c < 4; c++) begin
      frame_clk = (c % 2 == 0);
      step();
    end
    frame_clk = 1'b0;
    Reset = 1'b1;
    push("mid_reset", pk(0, 0, 0, 0, 0, 0, 0));
    step();
    Reset = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
    push("post_reset_no_br", pk(0, 0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
  endtask

  initial begin
    test_reset();
    test_goal_flash();
    test_simultaneous();
    test_game_over();
    test_hit_restart();
    test_reset_frame_high();
    test_reset_mid_flash();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
